screen_fetch: RTL and testbench
===============================

# screen_fetch

Parametrised LCD screen fetcher for the Z88 FPGA. It walks the character map at the Screen Base Register, fetching a 2-byte attribute and one pixel byte per cell and line through a request/acknowledge memory port. It applies lores/hires font selection and the REV/UND/FLS/GRY attributes, then writes one decoded pixel byte per cell into the VRAM line buffer. Successor to the fixed 108×64 fetcher: geometry is generic, memory arbitration is handshaked, and attributes are rendered.

## Interface
Parameters:
- COLS, 108, character cells per line; column counter width COL_W = clog2(COLS)
- LINES, 64, pixel lines per frame
- ROWS_PER_CHAR, 8, pixel lines per character row (power of two); RPC_W = log2, CROW_W = clog2(LINES/ROWS_PER_CHAR)
- MA_W, 22, memory address width
- VRAM_AW, 13, VRAM address width (≥ clog2(COLS*LINES))
- FLASH_FRAMES, 32, frames per flash half-period (power of two)

Ports:
- mck  in  1  system clock; all logic on rising edge
- rin_n  in  1  reset, asynchronous, active-low
- lcdon  in  1  display enable
- sbr  in  MA_W-CROW_W-COL_W-1  Screen Base Register
- pb0  in  MA_W-9  Lores0 (ROM) font base
- pb1  in  MA_W-12  Lores1 (RAM) font base
- pb2  in  MA_W-13  Hires0 (ROM) font base
- pb3  in  MA_W-11  Hires1 (RAM) font base
- mreq  out  1  screen memory request
- mack  in  1  memory grant; cdi valid when sampled high with mreq
- ma  out  MA_W  memory address
- cdi  in  8  memory read data
- vram_a  out  VRAM_AW  line-buffer address = slin*COLS + scol
- vram_do  out  8  decoded pixel byte
- vram_grey  out  1  GRY attribute for this cell
- vram_we  out  1  VRAM write strobe, one cycle
- frame_sync  out  1  one-cycle pulse after last cell of frame

## Operation
- Counters: scol 0..COLS-1, slin 0..LINES-1; char row = slin>>RPC_W, pixel row prow = slin[RPC_W-1:0].
- Attribute address: {sbr, char row, scol, b}, b=0 low byte, b=1 high byte; sba[13:0] = {cdi_hi[5:0], cdi_lo}.
- Attribute bits: 13 HRS, 12 REV, 11 FLS, 10 GRY, 9 UND (UND lores only).
- Pixel address: HRS=0, sba[8:6]=7 → {pb0, sba[5:0], prow}; HRS=0 otherwise → {pb1, sba[8:0], prow}; HRS=1, sba[9:8]=3 → {pb3, sba[7:0], prow}; else {pb2, sba[9:0], prow}. Pixel address is formed from the high attribute byte on cdi at the capturing edge.
- Decode, in order: lores masks pix to bits 5:0; UND and lores and prow=ROWS_PER_CHAR-1 → 8'h3F; REV → pix XOR (lores ? 8'h3F : 8'hFF); FLS and flash phase → 8'h00.
- FSM: IDLE → RQ_AL → RQ_AH → RQ_PX → WR → RQ_AL (next cell). RQ_x holds ma, mreq=1; advances only on an edge with mack=1, capturing cdi. WR asserts vram_we, then advances scol; at scol=COLS-1 scol wraps to 0 and slin increments; at slin=LINES-1 slin wraps to 0 and frame_sync pulses.
- IDLE → RQ_AL when lcdon=1. lcdon=0 in any state → IDLE next edge; scol/slin cleared, mreq dropped, no write.

## Timing
- Reset: mreq=0, ma=0, vram_a=0, vram_do=0, vram_grey=0, vram_we=0, frame_sync=0, FSM IDLE, counters 0, flash phase 0.
- All outputs registered. With mack tied high: 4 mck per cell (RQ_AL, RQ_AH, RQ_PX, WR); COLS*LINES*4 per frame.
- mack low stalls the current RQ state indefinitely; ma and mreq held stable.
- vram_we high exactly in WR; vram_a/vram_do/vram_grey valid in the same cycle.
- frame_sync asserts the cycle after WR of cell (COLS-1, LINES-1).
- Reset mid-access aborts immediately; no partial write.

## Configuration
- SCREEN_FLASH_EN defined: frame counter of log2(FLASH_FRAMES) bits increments on frame_sync; flash phase toggles at wrap; FLS blanks pixels during phase 1.
- Undefined: no frame counter; FLS ignored; pixels render as if phase 0.

## Test plan
- Reset, lcdon=1, mack=1, sbr=0: first ma = 0, then 1; first vram_we at cycle 4 with vram_a=0.
- Attr 0x0041 (lores, RAM font), pb1=1, prow=0, cdi pix=8'hFF → ma {pb1,9'h041,3'b0}, vram_do=8'h3F.
- Attr 0x3000 (HRS+REV, hires ROM), pix 8'hA5 → vram_do=8'h5A; attr with UND at prow=7 → 8'h3F.
- mack held low 5 cycles in RQ_AH → ma/mreq stable, cell takes 9 cycles.
- COLS=4, LINES=2: frame_sync after 8 writes, vram_a 0..7 then wraps to 0.
- SCREEN_FLASH_EN, FLASH_FRAMES=2, FLS cell pix 8'hFF: frames 0-1 → 8'hFF, frames 2-3 → 8'h00.

Source files
------------

// File: rtl/screen_fetch_if.sv
// rtl/screen_fetch_if.sv - screen fetcher memory request/acknowledge port and VRAM line-buffer write port
interface screen_fetch_if #(
  parameter int MA_W    = 22,
  parameter int VRAM_AW = 13
);
  logic               mreq;
  logic               mack;
  logic [MA_W-1:0]    ma;
  logic [7:0]         cdi;
  logic [VRAM_AW-1:0] vram_a;
  logic [7:0]         vram_do;
  logic               vram_grey;
  logic               vram_we;

  modport master (
    output mreq, ma, vram_a, vram_do, vram_grey, vram_we,
    input  mack, cdi
  );

  modport slave (
    input  mreq, ma, vram_a, vram_do, vram_grey, vram_we,
    output mack, cdi
  );
endinterface

// File: rtl/screen_fetch.sv
// rtl/screen_fetch.sv - LCD character-map fetcher with font select and REV/UND/FLS/GRY decode
// SCREEN_FLASH_EN enables the frame counter that drives FLS blinking.
module screen_fetch #(
  parameter int COLS          = 108,
  parameter int LINES         = 64,
  parameter int ROWS_PER_CHAR = 8,
  parameter int MA_W          = 22,
  parameter int VRAM_AW       = 13,
  parameter int FLASH_FRAMES  = 32,
  localparam int COL_W  = $clog2(COLS),
  localparam int LIN_W  = $clog2(LINES),
  localparam int RPC_W  = $clog2(ROWS_PER_CHAR),
  localparam int CROW_W = $clog2(LINES / ROWS_PER_CHAR),
  localparam int SBR_W  = MA_W - CROW_W - COL_W - 1
) (
  input  logic               mck,
  input  logic               rin_n,
  input  logic               lcdon,
  input  logic [SBR_W-1:0]   sbr,
  input  logic [MA_W-10:0]   pb0,
  input  logic [MA_W-13:0]   pb1,
  input  logic [MA_W-14:0]   pb2,
  input  logic [MA_W-12:0]   pb3,
  screen_fetch_if.master     bus,
  output logic               frame_sync
);

  typedef enum logic [2:0] {IDLE, RQ_AL, RQ_AH, RQ_PX, WR} state_t;

  state_t           state, state_n;
  logic [COL_W-1:0] scol, scol_n;
  logic [LIN_W-1:0] slin, slin_n;
  logic [7:0]       attr_lo;
  logic [4:0]       attr_flg;
  logic             frame_end;
  logic             last_col, last_lin;
  logic             flash_ph;
  logic [RPC_W-1:0] prow;
  logic [MA_W-1:0]  attr_addr, pix_addr;
  logic [9:0]       sba_l;
  logic             hrs_in;
  logic             lores;
  logic [7:0]       pix;

  assign prow     = slin[RPC_W-1:0];
  assign last_col = (scol == COL_W'(COLS - 1));
  assign last_lin = (slin == LIN_W'(LINES - 1));

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // lcdon low overrides every transition and rewinds the raster
  always_comb begin
    state_n   = state;
    scol_n    = scol;
    slin_n    = slin;
    frame_end = 1'b0;
    case (state)
      IDLE:  if (lcdon) state_n = RQ_AL;
      RQ_AL: if (bus.mack) state_n = RQ_AH;
      RQ_AH: if (bus.mack) state_n = RQ_PX;
      RQ_PX: if (bus.mack) state_n = WR;
      WR: begin
        state_n = RQ_AL;
        if (last_col) begin
          scol_n = '0;
          if (last_lin) begin
            slin_n    = '0;
            frame_end = 1'b1;
          end else begin
            slin_n = slin + LIN_W'(1);
          end
        end else begin
          scol_n = scol + COL_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (!lcdon) begin
      state_n   = IDLE;
      scol_n    = '0;
      slin_n    = '0;
      frame_end = 1'b0;
    end
  end

  // Attribute word sits at {sbr, char row, scol, b}; counters used are those of the cell being entered
  always_comb begin
    attr_addr = (MA_W'(sbr) << (CROW_W + COL_W + 1))
              | (MA_W'(slin_n >> RPC_W) << (COL_W + 1))
              | (MA_W'(scol_n) << 1);
  end

  // Font selection uses the high attribute byte while it is still on cdi
  always_comb begin
    sba_l  = {bus.cdi[1:0], attr_lo};
    hrs_in = bus.cdi[5];
    if (!hrs_in) begin
      if (sba_l[8:6] == 3'd7) begin
        pix_addr = (MA_W'({pb0, sba_l[5:0]}) << RPC_W) | MA_W'(prow);
      end else begin
        pix_addr = (MA_W'({pb1, sba_l[8:0]}) << RPC_W) | MA_W'(prow);
      end
    end else begin
      if (sba_l[9:8] == 2'd3) begin
        pix_addr = (MA_W'({pb3, sba_l[7:0]}) << RPC_W) | MA_W'(prow);
      end else begin
        pix_addr = (MA_W'({pb2, sba_l[9:0]}) << RPC_W) | MA_W'(prow);
      end
    end
  end

  // attr_flg = {HRS, REV, FLS, GRY, UND}
  always_comb begin
    lores = !attr_flg[4];
    pix   = bus.cdi;
    if (lores) pix = pix & 8'h3F;
    if (attr_flg[0] && lores && (prow == RPC_W'(ROWS_PER_CHAR - 1))) pix = 8'h3F;
    if (attr_flg[3]) pix = pix ^ (lores ? 8'h3F : 8'hFF);
    if (attr_flg[2] && flash_ph) pix = 8'h00;
  end

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      scol          <= '0;
      slin          <= '0;
      attr_lo       <= '0;
      attr_flg      <= '0;
      frame_sync    <= 1'b0;
      bus.mreq      <= 1'b0;
      bus.ma        <= '0;
      bus.vram_a    <= '0;
      bus.vram_do   <= '0;
      bus.vram_grey <= 1'b0;
      bus.vram_we   <= 1'b0;
    end else begin
      scol        <= scol_n;
      slin        <= slin_n;
      frame_sync  <= frame_end;
      bus.mreq    <= (state_n == RQ_AL) || (state_n == RQ_AH) || (state_n == RQ_PX);
      bus.vram_we <= (state_n == WR);
      if (state == RQ_AL && state_n == RQ_AH) attr_lo <= bus.cdi;
      if (state == RQ_AH && state_n == RQ_PX) attr_flg <= bus.cdi[5:1];
      // ma only moves on a state change so a stalled request keeps its address
      if (state_n != state) begin
        if (state_n == RQ_AL) bus.ma <= attr_addr;
        else if (state_n == RQ_AH) bus.ma <= attr_addr | MA_W'(1);
        else if (state_n == RQ_PX) bus.ma <= pix_addr;
      end
      if (state == RQ_PX && state_n == WR) begin
        bus.vram_a    <= VRAM_AW'(slin) * VRAM_AW'(COLS) + VRAM_AW'(scol);
        bus.vram_do   <= pix;
        bus.vram_grey <= attr_flg[1];
      end
    end
  end

`ifdef SCREEN_FLASH_EN
  localparam int FF_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic [FF_W-1:0] frame_cnt;
  logic            flash_q;

  always_ff @(posedge mck or negedge rin_n) begin
    if (!rin_n) begin
      frame_cnt <= '0;
      flash_q   <= 1'b0;
    end else if (frame_sync) begin
      if (frame_cnt == FF_W'(FLASH_FRAMES - 1)) begin
        frame_cnt <= '0;
        flash_q   <= !flash_q;
      end else begin
        frame_cnt <= frame_cnt + FF_W'(1);
      end
    end
  end

  assign flash_ph = flash_q;
`else
  assign flash_ph = 1'b0;
`endif

endmodule

// File: tb/tb_screen_fetch.sv
// tb/tb_screen_fetch.sv - randomized self-checking bench for screen_fetch against a raster-level model
module tb_screen_fetch;
  localparam int COLS = 4;
  localparam int LINES = 16;
  localparam int RPC = 8;
  localparam int MA_W = 22;
  localparam int VRAM_AW = 6;
  localparam int FFR = 2;

  logic        mck;
  logic        rin_n;
  logic        lcdon;
  logic [17:0] sbr;
  logic [12:0] pb0;
  logic [9:0]  pb1;
  logic [8:0]  pb2;
  logic [10:0] pb3;
  logic        frame_sync;

  screen_fetch_if #(.MA_W(MA_W), .VRAM_AW(VRAM_AW)) bus ();

  screen_fetch #(
    .COLS(COLS), .LINES(LINES), .ROWS_PER_CHAR(RPC),
    .MA_W(MA_W), .VRAM_AW(VRAM_AW), .FLASH_FRAMES(FFR)
  ) dut (
    .mck(mck), .rin_n(rin_n), .lcdon(lcdon), .sbr(sbr),
    .pb0(pb0), .pb1(pb1), .pb2(pb2), .pb3(pb3),
    .bus(bus), .frame_sync(frame_sync)
  );

  initial mck = 1'b0;
  always #5 mck = ~mck;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory: hashed contents with a few directed overrides
  logic [31:0] seed;
  logic [7:0]  ovr [logic [21:0]];

  function automatic logic [7:0] mem_byte(input logic [21:0] a);
    logic [31:0] x;
    if (ovr.exists(a)) return ovr[a];
    x = ({10'd0, a} * 32'h9E3779B1) ^ seed;
    x = x ^ (x >> 13);
    return x[7:0];
  endfunction

  function automatic logic [21:0] attr_addr(input int col, input int lin, input int b);
    longint v;
    v = ((longint'(sbr) * 2 + lin / RPC) * COLS + col) * 2 + b;
    return 22'(v);
  endfunction

  function automatic logic [13:0] cell_attr(input int col, input int lin);
    logic [7:0] lo, hi;
    lo = mem_byte(attr_addr(col, lin, 0));
    hi = mem_byte(attr_addr(col, lin, 1));
    return {hi[5:0], lo};
  endfunction

  function automatic logic [21:0] pix_addr(input logic [13:0] a, input int lin);
    longint v;
    int prow;
    prow = lin % RPC;
    if (!a[13]) begin
      if (a[8:6] == 3'd7) v = (longint'(pb0) * 64 + a[5:0]) * 8 + prow;
      else v = (longint'(pb1) * 512 + a[8:0]) * 8 + prow;
    end else begin
      if (a[9:8] == 2'd3) v = (longint'(pb3) * 256 + a[7:0]) * 8 + prow;
      else v = (longint'(pb2) * 1024 + a[9:0]) * 8 + prow;
    end
    return 22'(v);
  endfunction

  function automatic logic [7:0] exp_pix(input int col, input int lin, input bit ph);
    logic [13:0] a;
    logic [7:0]  px;
    bit          lores;
    a = cell_attr(col, lin);
    px = mem_byte(pix_addr(a, lin));
    lores = !a[13];
    if (lores) px = px & 8'h3F;
    if (a[9] && lores && (lin % RPC) == RPC - 1) px = 8'h3F;
    if (a[12]) px = px ^ (lores ? 8'h3F : 8'hFF);
    if (a[11] && ph) px = 8'h00;
    return px;
  endfunction

  int stall_pct = 0;
  bit hold_low = 0;

  int mcol, mlin, mstep, nframes;
  bit fs_due;

  // Memory responder and raster scoreboard, both on the falling edge
  always @(negedge mck) begin
    bit ph;
    logic [13:0] a;
    bus.mack = hold_low ? 1'b0 : ($urandom_range(99) >= stall_pct);
    bus.cdi  = mem_byte(bus.ma);
    if (!rin_n) begin
      mcol = 0; mlin = 0; mstep = 0; nframes = 0; fs_due = 0;
    end else begin
      check("frame_sync", 32'(frame_sync), 32'(fs_due));
      fs_due = 0;
      if (!lcdon) begin
        check("we_while_off", 32'(bus.vram_we), 0);
        mcol = 0; mlin = 0; mstep = 0;
      end else begin
`ifdef SCREEN_FLASH_EN
        ph = ((nframes / FFR) % 2) == 1;
`else
        ph = 0;
`endif
        if (bus.mreq && bus.mack) begin
          if (mstep == 0) check("ma_attr_lo", 32'(bus.ma), 32'(attr_addr(mcol, mlin, 0)));
          else if (mstep == 1) check("ma_attr_hi", 32'(bus.ma), 32'(attr_addr(mcol, mlin, 1)));
          else if (mstep == 2) check("ma_pix", 32'(bus.ma), 32'(pix_addr(cell_attr(mcol, mlin), mlin)));
          else check("extra_request", 32'(mstep), 2);
          mstep++;
        end
        if (bus.vram_we) begin
          a = cell_attr(mcol, mlin);
          check("write_after_3_reqs", 32'(mstep), 3);
          check("vram_a", 32'(bus.vram_a), 32'(mlin * COLS + mcol));
          check("vram_do", 32'(bus.vram_do), 32'(exp_pix(mcol, mlin, ph)));
          check("vram_grey", 32'(bus.vram_grey), 32'(a[10]));
          if (sbr == 0 && mcol == 2 && mlin == 7) check("und_row7", 32'(bus.vram_do), 32'h3F);
          if (sbr == 0 && mcol == 3 && mlin == 0) begin
`ifdef SCREEN_FLASH_EN
            check("fls_cell", 32'(bus.vram_do), (nframes % 4 >= 2) ? 32'h00 : 32'hFF);
`else
            check("fls_cell", 32'(bus.vram_do), 32'hFF);
`endif
          end
          mstep = 0;
          if (mcol == COLS - 1) begin
            mcol = 0;
            if (mlin == LINES - 1) begin
              mlin = 0;
              fs_due = 1;
              nframes++;
            end else begin
              mlin++;
            end
          end else begin
            mcol++;
          end
        end
      end
    end
  end

  task automatic wait_frames(input int n);
    int got;
    got = 0;
    for (int c = 0; c < 3000 * n && got < n; c++) begin
      @(posedge mck); #1;
      if (frame_sync) got++;
    end
    check("frames_done", 32'(got), 32'(n));
  endtask

  task automatic wait_mreq();
    bit seen;
    seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(posedge mck); #1;
      if (bus.mreq) seen = 1;
    end
    check("mreq_seen", 32'(seen), 1);
  endtask

  initial begin
    logic [21:0] ma_s;
    logic [21:0] k;
    seed  = $urandom;
    rin_n = 1'b0;
    lcdon = 1'b0;
    sbr   = '0;
    pb0   = 13'($urandom);
    pb1   = 10'd1;
    pb2   = 9'h100 | 9'($urandom);
    pb3   = 11'($urandom);
    ovr[22'd0] = 8'h41; ovr[22'd1] = 8'h00;
    ovr[22'd2] = 8'h00; ovr[22'd3] = 8'h30;
    ovr[22'd4] = 8'h00; ovr[22'd5] = 8'h02;
    ovr[22'd6] = 8'h02; ovr[22'd7] = 8'h28;
    ovr[22'h1208] = 8'hFF;
    k = 22'(longint'(pb2) * 8192);
    ovr[k] = 8'hA5;
    k = 22'((longint'(pb2) * 1024 + 2) * 8);
    ovr[k] = 8'hFF;

    repeat (2) @(posedge mck);
    #1;
    check("rst_mreq", 32'(bus.mreq), 0);
    check("rst_ma", 32'(bus.ma), 0);
    check("rst_vram_a", 32'(bus.vram_a), 0);
    check("rst_vram_do", 32'(bus.vram_do), 0);
    check("rst_grey", 32'(bus.vram_grey), 0);
    check("rst_we", 32'(bus.vram_we), 0);
    check("rst_fsync", 32'(frame_sync), 0);

    @(posedge mck); #1; rin_n = 1'b1;
    @(posedge mck); #1; lcdon = 1'b1;
    @(posedge mck); #1;
    check("c1_mreq", 32'(bus.mreq), 1);
    check("c1_ma", 32'(bus.ma), 0);
    @(posedge mck); #1;
    check("c2_ma", 32'(bus.ma), 1);
    @(posedge mck); #1;
    check("c3_ma_pix", 32'(bus.ma), 32'h1208);
    check("c3_we", 32'(bus.vram_we), 0);
    @(posedge mck); #1;
    check("c4_we", 32'(bus.vram_we), 1);
    check("c4_vram_a", 32'(bus.vram_a), 0);
    check("c4_lores_do", 32'(bus.vram_do), 32'h3F);
    repeat (4) @(posedge mck);
    #1;
    check("c8_we", 32'(bus.vram_we), 1);
    check("c8_vram_a", 32'(bus.vram_a), 1);
    check("c8_rev_do", 32'(bus.vram_do), 32'h5A);

    // Stall cell 2 in RQ_AH for five cycles
    @(posedge mck); #1;
    @(posedge mck); #1;
    hold_low = 1;
    ma_s = bus.ma;
    check("stall_ma_hi", 32'(ma_s), 5);
    for (int i = 0; i < 5; i++) begin
      @(posedge mck); #1;
      check("stall_ma", 32'(bus.ma), 32'(ma_s));
      check("stall_mreq", 32'(bus.mreq), 1);
      check("stall_we", 32'(bus.vram_we), 0);
    end
    hold_low = 0;
    @(posedge mck); #1;
    check("stall_c8_we", 32'(bus.vram_we), 0);
    @(posedge mck); #1;
    check("stall_c9_we", 32'(bus.vram_we), 1);
    check("stall_c9_a", 32'(bus.vram_a), 2);

    stall_pct = 30;
    wait_frames(5);

    wait_mreq();
    lcdon = 1'b0;
    @(posedge mck); #1;
    check("off_mreq", 32'(bus.mreq), 0);
    check("off_we", 32'(bus.vram_we), 0);
    repeat (3) @(posedge mck);
    #1;
    check("off_idle", 32'(bus.mreq), 0);
    sbr = 18'($urandom);
    lcdon = 1'b1;
    wait_frames(1);

    wait_mreq();
    repeat ($urandom_range(2)) @(posedge mck);
    #1;
    rin_n = 1'b0;
    #1;
    check("arst_mreq", 32'(bus.mreq), 0);
    check("arst_ma", 32'(bus.ma), 0);
    check("arst_we", 32'(bus.vram_we), 0);
    check("arst_vram_a", 32'(bus.vram_a), 0);
    @(posedge mck); #1;
    rin_n = 1'b1;
    sbr = '0;
    wait_frames(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
